// File: rtl/sfp_rx_deframer.sv
// sfp_rx_deframer: acquires link sync on IDLE ordered sets, delineates SOF/EOF frames,
// streams payload and checks each frame's length and 16-bit checksum.
module sfp_rx_deframer #(
    parameter int MAX_LEN  = 256,
    parameter int SYNC_CNT = 4,
    parameter int LOSS_CNT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] rx_data,
    input  logic [1:0]  rx_datak,
    input  logic [1:0]  rx_errdetect,
    input  logic        rx_valid,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        frame_done,
    output logic        frame_good,
    output logic        link_up,
    output logic [15:0] good_cnt,
    output logic [15:0] err_cnt
);
    localparam logic [15:0] MAX_N  = 16'(MAX_LEN);
    localparam logic [15:0] SYNC_N = 16'(SYNC_CNT);
    localparam logic [15:0] LOSS_N = 16'(LOSS_CNT);

    typedef enum logic [2:0] {UNSYNC, IDLE, HDR, PAY, CKS, EOFW} state_t;

    state_t      state_q, state_d;
    logic [15:0] sync_q, sync_d, loss_q, loss_d;
    logic [15:0] cnt_q, cnt_d, cks_q, cks_d;
    logic [15:0] good_cnt_q, good_cnt_d, err_cnt_q, err_cnt_d;
    logic        first_q, first_d, link_q, link_d;
    logic [15:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
    logic        done_q, done_d, good_q, good_d;
    logic        err_w, is_idle, is_sof, is_eof, is_dat, bad;

    always_comb begin
        err_w   = |rx_errdetect;
        is_idle = !err_w && rx_datak == 2'b01 && rx_data == 16'h50BC;
        is_sof  = !err_w && rx_datak == 2'b11 && rx_data == 16'hFBBC;
        is_eof  = !err_w && rx_datak == 2'b11 && rx_data == 16'hFDBC;
        is_dat  = !err_w && rx_datak == 2'b00;
        bad         = 1'b0;
        state_d     = state_q;
        sync_d      = sync_q;
        loss_d      = loss_q;
        cnt_d       = cnt_q;
        cks_d       = cks_q;
        good_cnt_d  = good_cnt_q;
        err_cnt_d   = err_cnt_q;
        first_d     = first_q;
        link_d      = link_q;
        out_data_d  = 16'd0;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        out_eof_d   = 1'b0;
        done_d      = 1'b0;
        good_d      = 1'b0;
        if (rx_valid && state_q == UNSYNC) begin
            sync_d = is_idle ? sync_q + 16'd1 : 16'd0;
            if (is_idle && sync_q + 16'd1 == SYNC_N) begin
                link_d  = 1'b1;
                state_d = IDLE;
                sync_d  = 16'd0;
                loss_d  = 16'd0;
            end
        end else if (rx_valid) begin
            case (state_q)
                IDLE: state_d = is_sof ? HDR : IDLE;
                HDR: begin
                    if (is_dat && rx_data != 16'd0 && rx_data <= MAX_N) begin
                        cnt_d   = rx_data;
                        cks_d   = rx_data;
                        first_d = 1'b1;
                        state_d = PAY;
                    end else bad = 1'b1;
                end
                PAY: begin
                    if (is_dat) begin
                        out_valid_d = 1'b1;
                        out_data_d  = rx_data;
                        out_sof_d   = first_q;
                        out_eof_d   = cnt_q == 16'd1;
                        first_d     = 1'b0;
                        cnt_d       = cnt_q - 16'd1;
                        cks_d       = cks_q + rx_data;
                        state_d     = cnt_q == 16'd1 ? CKS : PAY;
                    end else bad = 1'b1;
                end
                CKS: begin
                    if (is_dat && rx_data == cks_q) state_d = EOFW;
                    else bad = 1'b1;
                end
                EOFW: begin
                    if (is_eof) begin
                        done_d     = 1'b1;
                        good_d     = 1'b1;
                        good_cnt_d = good_cnt_q + {15'd0, good_cnt_q != 16'hFFFF};
                        state_d    = IDLE;
                    end else bad = 1'b1;
                end
                default: state_d = state_q;
            endcase
            // a fresh SOF mid-frame aborts the old frame and starts the new header at once
            if (bad) begin
                done_d    = 1'b1;
                err_cnt_d = err_cnt_q + {15'd0, err_cnt_q != 16'hFFFF};
                state_d   = (is_sof && state_q != HDR) ? HDR : IDLE;
            end
            loss_d = err_w ? loss_q + 16'd1 : 16'd0;
            if (err_w && loss_q + 16'd1 == LOSS_N) begin
                link_d  = 1'b0;
                state_d = UNSYNC;
                loss_d  = 16'd0;
                sync_d  = 16'd0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= UNSYNC;
            sync_q      <= 16'd0;
            loss_q      <= 16'd0;
            cnt_q       <= 16'd0;
            cks_q       <= 16'd0;
            good_cnt_q  <= 16'd0;
            err_cnt_q   <= 16'd0;
            first_q     <= 1'b0;
            link_q      <= 1'b0;
            out_data_q  <= 16'd0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            done_q      <= 1'b0;
            good_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            loss_q      <= loss_d;
            cnt_q       <= cnt_d;
            cks_q       <= cks_d;
            good_cnt_q  <= good_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_q     <= first_d;
            link_q      <= link_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            done_q      <= done_d;
            good_q      <= good_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_sof    = out_sof_q;
    assign out_eof    = out_eof_q;
    assign frame_done = done_q;
    assign frame_good = good_q;
    assign link_up    = link_q;
    assign good_cnt   = good_cnt_q;
    assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_sfp_rx_deframer.sv
// tb_sfp_rx_deframer: directed frames with a scoreboard of expected output events.
module tb_sfp_rx_deframer;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] rx_data = 16'd0;
    logic [1:0]  rx_datak = 2'b00;
    logic [1:0]  rx_errdetect = 2'b00;
    logic        rx_valid = 1'b0;
    logic [15:0] out_data, good_cnt, err_cnt;
    logic        out_valid, out_sof, out_eof, frame_done, frame_good, link_up;

    sfp_rx_deframer dut (
        .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_datak(rx_datak),
        .rx_errdetect(rx_errdetect), .rx_valid(rx_valid), .out_data(out_data),
        .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
        .frame_done(frame_done), .frame_good(frame_good), .link_up(link_up),
        .good_cnt(good_cnt), .err_cnt(err_cnt)
    );

    always #5 CLK = ~CLK;

    // entry = {valid, sof, eof, done, good, data}
    logic [20:0] exp_q[$];
    logic [20:0] obs;
    int pass_cnt = 0;
    int total_cnt = 0;
    bit gaps = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge CLK) begin
        obs = {out_valid, out_sof, out_eof, frame_done, frame_good, out_data};
        if (obs[20:16] != 5'd0) begin
            if (exp_q.size() == 0) chk("unexpected_output", 32'(obs), 32'd0);
            else chk("output_event", 32'(obs), 32'(exp_q.pop_front()));
        end
    end

    task automatic gap();
        @(negedge CLK);
        rx_valid = 1'b0;
        rx_data  = 16'hFBBC;
        rx_datak = 2'b11;
        @(posedge CLK);
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] k, input logic [1:0] e);
        @(negedge CLK);
        rx_data = d;
        rx_datak = k;
        rx_errdetect = e;
        rx_valid = 1'b1;
        @(posedge CLK);
        #1 rx_valid = 1'b0;
        if (gaps) repeat (2) gap();
    endtask

    task automatic idle();          send(16'h50BC, 2'b01, 2'b00); endtask
    task automatic sof();           send(16'hFBBC, 2'b11, 2'b00); endtask
    task automatic eof();           send(16'hFDBC, 2'b11, 2'b00); endtask
    task automatic dat(input logic [15:0] d); send(d, 2'b00, 2'b00); endtask
    task automatic beat(input logic [15:0] d, input logic s, input logic e);
        exp_q.push_back({1'b1, s, e, 2'b00, d});
    endtask
    task automatic done(input logic g);
        exp_q.push_back({3'b000, 1'b1, g, 16'h0000});
    endtask
    task automatic settle(); @(negedge CLK); endtask

    task automatic frame3(input logic [15:0] cks);
        sof();
        dat(16'h0003);
        beat(16'h1111, 1'b1, 1'b0); dat(16'h1111);
        beat(16'h2222, 1'b0, 1'b0); dat(16'h2222);
        beat(16'h3333, 1'b0, 1'b1); dat(16'h3333);
        done(cks == 16'h6669);      dat(cks);
        eof();
    endtask

    task automatic abort_then_good();
        sof(); dat(16'h0002);
        beat(16'hAAAA, 1'b1, 1'b0); dat(16'hAAAA);
        done(1'b0); sof();
        dat(16'h0002);
        beat(16'h1000, 1'b1, 1'b0); dat(16'h1000);
        beat(16'h2000, 1'b0, 1'b1); dat(16'h2000);
        dat(16'h3002);
        done(1'b1); eof();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK) RST = 1'b0;
        settle();
        chk("reset_link_up", 32'(link_up), 32'd0);
        chk("reset_good_cnt", 32'(good_cnt), 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);

        repeat (3) idle();
        dat(16'h1234);
        repeat (3) idle();
        settle();
        chk("sync_broken_run", 32'(link_up), 32'd0);
        idle();
        settle();
        chk("sync_acquired", 32'(link_up), 32'd1);

        frame3(16'h6669);
        settle();
        chk("good_frame_cnt", 32'(good_cnt), 32'd1);

        frame3(16'h6668);
        settle();
        chk("bad_cks_err_cnt", 32'(err_cnt), 32'd1);
        sof(); dat(16'h0001);
        beat(16'hABCD, 1'b1, 1'b1); dat(16'hABCD);
        dat(16'hABCE);
        done(1'b1); eof();
        settle();
        chk("len1_good_cnt", 32'(good_cnt), 32'd2);

        sof(); done(1'b0); dat(16'h0000);
        sof(); done(1'b0); dat(16'h0101);
        settle();
        chk("bad_len_err_cnt", 32'(err_cnt), 32'd3);

        abort_then_good();
        settle();
        chk("abort_err_cnt", 32'(err_cnt), 32'd4);
        chk("abort_good_cnt", 32'(good_cnt), 32'd3);

        gaps = 1'b1;
        abort_then_good();
        gaps = 1'b0;
        settle();
        chk("gaps_err_cnt", 32'(err_cnt), 32'd5);
        chk("gaps_good_cnt", 32'(good_cnt), 32'd4);

        sof(); dat(16'h0003);
        beat(16'h1111, 1'b1, 1'b0); dat(16'h1111);
        done(1'b0);
        repeat (3) send(16'h2222, 2'b00, 2'b01);
        settle();
        chk("loss_not_yet", 32'(link_up), 32'd1);
        send(16'h2222, 2'b00, 2'b01);
        settle();
        chk("loss_link_down", 32'(link_up), 32'd0);
        chk("loss_err_cnt", 32'(err_cnt), 32'd6);
        sof(); dat(16'h0001); dat(16'h0005); dat(16'h0006); eof();
        repeat (3) idle();
        settle();
        chk("resync_partial", 32'(link_up), 32'd0);
        idle();
        settle();
        chk("resync_done", 32'(link_up), 32'd1);

        @(negedge CLK) force dut.err_cnt_q = 16'hFFFD;
        @(negedge CLK) release dut.err_cnt_q;
        settle();
        chk("preload_err_cnt", 32'(err_cnt), 32'h0000FFFD);
        repeat (3) begin
            sof(); done(1'b0); dat(16'h0000);
        end
        settle();
        chk("sat_err_cnt", 32'(err_cnt), 32'h0000FFFF);
        sof(); done(1'b0); dat(16'h0000);
        settle();
        chk("sat_err_hold", 32'(err_cnt), 32'h0000FFFF);
        chk("sat_good_cnt", 32'(good_cnt), 32'd4);

        sof(); dat(16'h0002);
        beat(16'h0101, 1'b1, 1'b0); dat(16'h0101);
        @(negedge CLK) RST = 1'b1;
        @(negedge CLK) RST = 1'b0;
        dat(16'h0202); dat(16'h0305); eof();
        settle();
        chk("midreset_link_up", 32'(link_up), 32'd0);
        chk("midreset_err_cnt", 32'(err_cnt), 32'd0);
        chk("midreset_good_cnt", 32'(good_cnt), 32'd0);

        repeat (3) settle();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/sfp_rx_deframer.md
Name: sfp_rx_deframer

Overview:
Receive-side link-layer stage that sits directly downstream of the SFP transceiver RX FIFO. It consumes the 16-bit de-serialised word stream (two 8b10b-decoded bytes plus per-byte K flags) and acquires link sync on idle ordered sets. It then delineates SOF/EOF-bounded frames, streams payload words out, and verifies each frame's length and 16-bit checksum. Frame status and saturating good/error counters go to the BSP status registers.

Parameters:
MAX_LEN, 256, maximum legal payload length in 16-bit words (1..65535)
SYNC_CNT, 4, consecutive clean IDLE words required to declare link up
LOSS_CNT, 4, consecutive words with decode errors that drop link

Ports:
CLK  in  1  single clock for all logic
RST  in  1  synchronous active-high reset
rx_data  in  16  received word; byte0=[7:0], byte1=[15:8]
rx_datak  in  2  K-character flag per byte ([0]=byte0)
rx_errdetect  in  2  8b10b code/disparity error per byte
rx_valid  in  1  rx_data/rx_datak/rx_errdetect qualify this cycle
out_data  out  16  payload word
out_valid  out  1  out_data valid
out_sof  out  1  first payload word of frame
out_eof  out  1  last payload word of frame
frame_done  out  1  one-cycle pulse: frame ended (good or bad)
frame_good  out  1  qualifies frame_done; 1 = length and checksum OK
link_up  out  1  link synchronised
good_cnt  out  16  good frames, saturating at 16'hFFFF
err_cnt  out  16  bad/aborted frames, saturating at 16'hFFFF

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST). At reset, all outputs are 0, state = UNSYNC, and counters are cleared. RST mid-frame discards the frame with no frame_done.
- Control words (datak=2'b11 unless noted): IDLE=16'h50BC datak=2'b01; SOF=16'hFBBC; EOF=16'hFDBC.
- Words are only examined when rx_valid=1. Cycles with rx_valid=0 freeze all state and counters.
- Sync: in UNSYNC, count consecutive IDLE words with rx_errdetect=0. Any other word resets the count. On reaching SYNC_CNT, set link_up=1 and go to IDLE.
- Loss of sync: while link_up=1, LOSS_CNT consecutive words with rx_errdetect!=0 clear link_up and go to UNSYNC. Any clean word resets the loss count. If a frame is in progress, it is aborted with an error.
- States: UNSYNC, IDLE, HDR, PAY, CKS, EOFW.
- IDLE: SOF -> HDR. All other words are ignored.
- HDR: the word is LEN. LEN=0, LEN>MAX_LEN, or any K flag set is an error. Otherwise load the word counter with LEN, seed the checksum with LEN, and go to PAY.
- PAY: each data word (datak=0) is emitted, added to the checksum mod 2^16, and decrements the counter. After the LEN-th word, go to CKS.
- CKS: if the data word equals the running checksum -> EOFW, else error.
- EOFW: EOF -> frame_done=1 with frame_good=1, and good_cnt increments. Anything else is an error.
- Error in HDR/PAY/CKS/EOFW (including rx_errdetect!=0 or an unexpected K word): frame_done=1, frame_good=0, err_cnt increments, state -> IDLE.
- SOF received in PAY/CKS/EOFW: abort the current frame as an error, then go directly to HDR for the new frame in the same cycle. This is not counted as a second event.
- Latency: out_* and frame_done are registered, one cycle after the qualifying input word.
- out_sof and out_eof are both high when LEN=1.
- Payload of bad frames has already been emitted. Downstream drops the frame on frame_done with frame_good=0.
- No backpressure: the output cannot stall. out_valid is asserted at most once per accepted input word.
- frame_done, frame_good and out_* are 0 in all cycles not described above.
- good_cnt/err_cnt hold at 16'hFFFF and do not wrap.

Test Plan:
- Reset, then 4 clean IDLE words -> link_up=1 one cycle after the 4th word. Inject 3 IDLE, 1 D-word, 3 IDLE -> link_up stays 0.
- Good frame: SOF, 16'h0003, 16'h1111, 16'h2222, 16'h3333, 16'h6669, EOF -> three out_valid beats (sof on 1111, eof on 3333), then frame_done=1, frame_good=1, good_cnt=1.
- Same frame with checksum 16'h6668 -> payload emitted, frame_done=1, frame_good=0, err_cnt=1, next SOF accepted normally.
- LEN=0 and LEN=257 (MAX_LEN=256) -> immediate error frame_done with no out_valid. LEN=1 -> single beat with out_sof=out_eof=1.
- SOF inserted after 1 payload word, followed by a full good frame -> err_cnt=1, good_cnt=1, second frame emitted intact. rx_valid gaps inside the frame -> identical result.
- 4 consecutive words with rx_errdetect=2'b01 mid-frame -> link_up=0, frame_done/frame_good=0, err_cnt increments. Preload err_cnt near saturation, then force errors -> holds at 16'hFFFF.
